// File: rtl/packed_field_pkg.sv
// Shared types and helpers for the packed field writer.
// Optional readback of the previous field is enabled by defining
// FIELD_WRITER_READBACK_EN (see packed_field_writer).
package packed_field_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,   // ascending  +:
        DIR_DOWN = 1'b1    // descending -:
    } dir_e;

    // Field widths the writer accepts.
    localparam int WIDTH_1 = 1;
    localparam int WIDTH_2 = 2;
    localparam int WIDTH_4 = 4;
    localparam int WIDTH_8 = 8;

    function automatic logic is_legal_width(input logic signed [31:0] w);
        return (w == WIDTH_1) || (w == WIDTH_2) || (w == WIDTH_4) || (w == WIDTH_8);
    endfunction

endpackage

// File: rtl/packed_field_range_check.sv
// Combinational legality check and bit-enable mask for one indexed
// part-select (+: or -:) on a VEC_W-bit vector. Also reports the lowest
// bit index of the field so the caller can align data to it.
module packed_field_range_check
    import packed_field_pkg::*;
#(
    parameter int VEC_W = 32
) (
    input  logic signed [31:0] i_start,
    input  logic signed [31:0] i_width,
    input  dir_e               i_dir,
    output logic               o_legal,
    output logic signed [31:0] o_lo,
    output logic [VEC_W-1:0]   o_mask
);

    logic               w_width_ok;
    logic               w_up_ok;
    logic               w_down_ok;
    logic signed [31:0] w_hi;

    // Width is gated first, so the subtractions below can never overflow
    // for a request that is finally declared legal. The upper bound is
    // written as start <= VEC_W - width so a huge start cannot wrap.
    always_comb begin
        w_width_ok = is_legal_width(i_width);
        w_up_ok    = (i_start >= 0) && (i_start <= (VEC_W - i_width));
        w_down_ok  = (i_start >= (i_width - 1)) && (i_start < VEC_W);
        o_legal    = w_width_ok && ((i_dir == DIR_DOWN) ? w_down_ok : w_up_ok);
        o_lo       = (i_dir == DIR_DOWN) ? (i_start - i_width + 1) : i_start;
        w_hi       = o_lo + i_width - 1;
    end

    // One enable per vector bit: set when the bit lies inside [lo, hi].
    generate
        for (genvar gi = 0; gi < VEC_W; gi++) begin : g_mask
            localparam logic signed [31:0] BIT_IDX = gi;
            assign o_mask[gi] = o_legal && (BIT_IDX >= o_lo) && (BIT_IDX <= w_hi);
        end
    endgenerate

endmodule

// File: rtl/packed_field_writer.sv
// Sequential writer of 1/2/4/8-bit fields into a held VEC_W-bit vector.
// One request at a time: IDLE accepts, EXEC checks and writes, RESP holds
// the response until consumed.
// Define FIELD_WRITER_READBACK_EN to return the previous field contents
// on rsp_old; otherwise rsp_old is constant zero.
module packed_field_writer
    import packed_field_pkg::*;
#(
    parameter int VEC_W  = 32,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic signed [31:0] req_start,
    input  logic signed [31:0] req_width,
    input  logic               req_dir,
    input  logic [DATA_W-1:0]  req_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_err,
    output logic [DATA_W-1:0]  rsp_old,
    output logic [VEC_W-1:0]   vec_out
);

    state_e             r_state;
    state_e             w_state_next;

    logic signed [31:0] r_start;
    logic signed [31:0] r_width;
    dir_e               r_dir;
    logic [DATA_W-1:0]  r_data;

    logic [VEC_W-1:0]   r_vec;
    logic               r_rsp_err;

    logic               w_legal;
    logic signed [31:0] w_lo;
    logic [VEC_W-1:0]   w_mask;
    logic [VEC_W-1:0]   w_field;

    // Range check works on the captured request, so it is only meaningful in EXEC.
    packed_field_range_check #(
        .VEC_W (VEC_W)
    ) u_range_check (
        .i_start (r_start),
        .i_width (r_width),
        .i_dir   (r_dir),
        .o_legal (w_legal),
        .o_lo    (w_lo),
        .o_mask  (w_mask)
    );

    // Data aligned to the field's low bit; the mask discards data bits above width.
    assign w_field = VEC_W'(r_data) << w_lo;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: EXEC is always a single cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Capture the request on acceptance; requests outside IDLE are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= '0;
            r_width <= '0;
            r_dir   <= DIR_UP;
            r_data  <= '0;
        end else if ((r_state == IDLE) && req_valid) begin
            r_start <= req_start;
            r_width <= req_width;
            r_dir   <= dir_e'(req_dir);
            r_data  <= req_data;
        end
    end

    // Held vector: clear wins over a same-cycle field write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec <= '0;
        end else if (clear) begin
            r_vec <= '0;
        end else if ((r_state == EXEC) && w_legal) begin
            r_vec <= (r_vec & ~w_mask) | (w_field & w_mask);
        end
    end

    // Error flag is loaded in EXEC and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_err <= !w_legal;
        end
    end

`ifdef FIELD_WRITER_READBACK_EN
    logic [DATA_W-1:0] r_rsp_old;
    logic [DATA_W-1:0] w_old_field;

    // Old field uses the same mask/alignment as the write, sampled before it lands.
    assign w_old_field = DATA_W'((r_vec & w_mask) >> w_lo);

    // Readback loaded in EXEC; zero for illegal requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_old <= '0;
        end else if (r_state == EXEC) begin
            r_rsp_old <= w_legal ? w_old_field : '0;
        end
    end

    assign rsp_old = r_rsp_old;
`else
    assign rsp_old = '0;
`endif

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = r_rsp_err;
    assign vec_out   = r_vec;

endmodule

// File: tb/tb_packed_field_writer.sv
// Directed self-checking bench for packed_field_writer.
// Expected rsp_old values follow FIELD_WRITER_READBACK_EN.
module tb_packed_field_writer;

    logic               clk;
    logic               rst_n;
    logic               clear;
    logic               req_valid;
    logic               req_ready;
    logic signed [31:0] req_start;
    logic signed [31:0] req_width;
    logic               req_dir;
    logic [7:0]         req_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_err;
    logic [7:0]         rsp_old;
    logic [31:0]        vec_out;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FIELD_WRITER_READBACK_EN
    localparam logic [7:0] RB_MASK = 8'hFF;
`else
    localparam logic [7:0] RB_MASK = 8'h00;
`endif

    packed_field_writer #(
        .VEC_W  (32),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_start (req_start),
        .req_width (req_width),
        .req_dir   (req_dir),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_err   (rsp_err),
        .rsp_old   (rsp_old),
        .vec_out   (vec_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_old(input logic [7:0] v);
        return v & RB_MASK;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Full transaction with rsp_ready held high; returns the response payload.
    task automatic do_req(input int start, input int width, input logic dir,
                          input logic [7:0] data, output logic err, output logic [7:0] old);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_start = start;
        req_width = width;
        req_dir   = dir;
        req_data  = data;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("exec_req_ready", {31'b0, req_ready}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
        check("rsp_latency", n, 32'd1);
        err = rsp_err;
        old = rsp_old;
        @(posedge clk);
        @(negedge clk);
        check("back_to_idle", {31'b0, req_ready}, 32'd1);
        $display("txn start=%0d width=%0d dir=%0d data=%02h err=%0d old=%02h vec=%08h",
                 start, width, dir, data, err, old, vec_out);
    endtask

    task automatic legal_req(input string tag, input int start, input int width, input logic dir,
                             input logic [7:0] data, input logic [7:0] old_exp, input logic [31:0] vec_exp);
        logic       e;
        logic [7:0] o;
        do_req(start, width, dir, data, e, o);
        check({tag, "_err"}, {31'b0, e}, 32'd0);
        check({tag, "_old"}, {24'b0, o}, {24'b0, exp_old(old_exp)});
        check({tag, "_vec"}, vec_out, vec_exp);
    endtask

    int         ill_start [8] = '{28, 2, 0, -1, 32, 0, 32'h7FFF_FFFF, 5};
    int         ill_width [8] = '{8, 4, 3, 1, 1, 0, 1, -2};
    logic       ill_dir   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        logic       e;
        logic [7:0] o;

        rst_n     = 1'b0;
        clear     = 1'b0;
        req_valid = 1'b0;
        req_start = '0;
        req_width = '0;
        req_dir   = 1'b0;
        req_data  = '0;
        rsp_ready = 1'b0;

        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
        check("rst_rsp_old",   {24'b0, rsp_old},   32'd0);
        check("rst_vec",       vec_out,            32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic ascending / descending writes.
        legal_req("up4",    4, 4, 1'b0, 8'hA5, 8'h00, 32'h0000_0050);
        legal_req("dn31",  31, 8, 1'b1, 8'h3C, 8'h00, 32'h3C00_0050);
        // Overwrites with nonzero old contents.
        legal_req("up4w8",  4, 8, 1'b0, 8'hFF, 8'h05, 32'h3C00_0FF0);
        legal_req("dn31w4",31, 4, 1'b1, 8'h00, 8'h03, 32'h0C00_0FF0);
        // Boundary-legal placements; high data bits must be ignored.
        legal_req("up24",  24, 8, 1'b0, 8'hAB, 8'h0C, 32'hAB00_0FF0);
        legal_req("dn7",    7, 8, 1'b1, 8'h12, 8'hF0, 32'hAB00_0F12);
        legal_req("up31",  31, 1, 1'b0, 8'hFE, 8'h01, 32'h2B00_0F12);
        legal_req("dn1",    1, 2, 1'b1, 8'hFD, 8'h02, 32'h2B00_0F11);

        // Illegal requests: error, zero readback, vector untouched.
        for (int i = 0; i < 8; i++) begin
            do_req(ill_start[i], ill_width[i], ill_dir[i], 8'hFF, e, o);
            check($sformatf("ill%0d_err", i), {31'b0, e}, 32'd1);
            check($sformatf("ill%0d_old", i), {24'b0, o}, 32'd0);
            check($sformatf("ill%0d_vec", i), vec_out, 32'h2B00_0F11);
        end

        // Back-pressure on the response; a new request during RESP is ignored.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_start = 5;
        req_width = 2;
        req_dir   = 1'b0;
        req_data  = 8'h03;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("hold_exec_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        req_valid = 1'b1;
        req_start = 0;
        req_width = 8;
        req_data  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("hold_ready", {31'b0, req_ready}, 32'd0);
            check("hold_err",   {31'b0, rsp_err},   32'd0);
            check("hold_old",   {24'b0, rsp_old},   {24'b0, exp_old(8'h00)});
            check("hold_vec",   vec_out,            32'h2B00_0F71);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("hold_release_ready", {31'b0, req_ready}, 32'd1);
        check("hold_release_valid", {31'b0, rsp_valid}, 32'd0);
        check("hold_release_vec",   vec_out,            32'h2B00_0F71);
        $display("txn hold start=5 width=2 dir=0 data=03 vec=%08h", vec_out);

        // clear during EXEC beats the write; response still normal.
        @(negedge clk);
        req_valid = 1'b1;
        req_start = 0;
        req_width = 8;
        req_dir   = 1'b0;
        req_data  = 8'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_vec",   vec_out,            32'd0);
        check("clr_valid", {31'b0, rsp_valid}, 32'd1);
        check("clr_err",   {31'b0, rsp_err},   32'd0);
        check("clr_old",   {24'b0, rsp_old},   {24'b0, exp_old(8'h71)});
        @(negedge clk);
        check("clr_idle", {31'b0, req_ready}, 32'd1);
        check("clr_vec2", vec_out,            32'd0);
        $display("txn clear start=0 width=8 dir=0 data=55 vec=%08h", vec_out);

        // Reset while in RESP abandons the response.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_start = 8;
        req_width = 8;
        req_dir   = 1'b0;
        req_data  = 8'hCC;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rr_valid", {31'b0, rsp_valid}, 32'd1);
        check("rr_vec",   vec_out,            32'h0000_CC00);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_async_vec",   vec_out,            32'd0);
        check("rr_async_valid", {31'b0, rsp_valid}, 32'd0);
        check("rr_async_ready", {31'b0, req_ready}, 32'd1);
        check("rr_async_err",   {31'b0, rsp_err},   32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rr_no_rsp",  {31'b0, rsp_valid}, 32'd0);
        check("rr_ready",   {31'b0, req_ready}, 32'd1);
        $display("txn reset_in_resp vec=%08h", vec_out);

        legal_req("post", 0, 1, 1'b0, 8'hFF, 8'h00, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
